// File: rtl/main_mem_pkg.sv
// Shared state encoding and line-geometry helpers for the burst main memory.
package main_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_BURST,
        CLEAR
    } state_e;

    // Width of the beat counter for a given burst length.
    function automatic int unsigned beat_width(input int unsigned burst_len);
        return $clog2(burst_len);
    endfunction

    // Mask selecting the word-offset bits within one aligned line.
    function automatic int unsigned line_mask(input int unsigned burst_len);
        return burst_len - 1;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM: one read or one write per cycle, registered read data.
module mem_array #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately left unreset; only the read register clears.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/main_mem_burst.sv
// Burst main memory: line fills/writebacks over valid/ready channels plus a flush sweep.
// Define CRITICAL_WORD_FIRST_EN to start read bursts at the requested word.
module main_mem_burst
    import main_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  flush,
    output logic                  flush_busy
);

    localparam int unsigned BW = beat_width(BURST_LEN);
    localparam int unsigned LW = $clog2(RD_LATENCY) + 1;

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(line_mask(BURST_LEN));
    localparam logic [BW-1:0]         LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [LW-1:0]         LAST_WAIT = LW'(RD_LATENCY - 1);

    state_e                state_q, state_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [LW-1:0]         lat_q, lat_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  flush_pending_q, flush_pending_d;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic [BW-1:0]         off_cur, off_nxt;
    logic [ADDR_WIDTH-1:0] addr_cur, addr_nxt;
    logic [ADDR_WIDTH-1:0] wr_base, rd_base;
    logic                  rd_fire, wr_fire;

    // Beat offsets wrap inside the aligned line; the line bits never change.
    assign off_cur  = base_q[BW-1:0] + beat_q;
    assign off_nxt  = base_q[BW-1:0] + beat_q + 1'b1;
    assign addr_cur = {base_q[ADDR_WIDTH-1:BW], off_cur};
    assign addr_nxt = {base_q[ADDR_WIDTH-1:BW], off_nxt};

    assign wr_base = req_addr & ~LINE_MASK;
`ifdef CRITICAL_WORD_FIRST_EN
    assign rd_base = req_addr;
`else
    assign rd_base = req_addr & ~LINE_MASK;
`endif

    assign req_ready  = (state_q == IDLE);
    assign rd_valid   = (state_q == RD_BURST);
    assign wr_ready   = (state_q == WR_BURST);
    assign flush_busy = (state_q == CLEAR);
    assign rd_data    = mem_rdata;

    assign rd_fire = rd_valid && rd_ready;
    assign wr_fire = wr_valid && wr_ready;

    always_comb begin
        state_d         = state_q;
        beat_d          = beat_q;
        lat_d           = lat_q;
        ptr_d           = ptr_q;
        base_d          = base_q;
        flush_pending_d = flush_pending_q;
        mem_en          = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = addr_cur;
        mem_wdata       = wr_data;

        // A flush arriving mid-burst is remembered until the burst finishes.
        if (flush && (state_q != IDLE) && (state_q != CLEAR)) begin
            flush_pending_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                beat_d = '0;
                lat_d  = '0;
                if (flush || flush_pending_q) begin
                    state_d         = CLEAR;
                    ptr_d           = '0;
                    flush_pending_d = 1'b0;
                end else if (req_valid) begin
                    if (req_we) begin
                        base_d  = wr_base;
                        state_d = WR_BURST;
                    end else begin
                        base_d  = rd_base;
                        state_d = RD_WAIT;
                    end
                end
            end

            RD_WAIT: begin
                // Keep reading the first beat so it is registered on exit.
                mem_en = 1'b1;
                lat_d  = lat_q + 1'b1;
                if (lat_q == LAST_WAIT) begin
                    lat_d   = '0;
                    state_d = RD_BURST;
                end
            end

            RD_BURST: begin
                mem_en = 1'b1;
                if (rd_fire) begin
                    mem_addr = addr_nxt;
                    beat_d   = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end

            WR_BURST: begin
                if (wr_fire) begin
                    mem_en = 1'b1;
                    mem_we = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end

            CLEAR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = ptr_q;
                mem_wdata = '0;
                ptr_d     = ptr_q + 1'b1;
                if (ptr_q == '1) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            beat_q          <= '0;
            lat_q           <= '0;
            ptr_q           <= '0;
            base_q          <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            beat_q          <= beat_d;
            lat_q           <= lat_d;
            ptr_q           <= ptr_d;
            base_q          <= base_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mem_array (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (mem_en),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(mem_wdata),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_main_mem_burst.sv
// Directed bench for main_mem_burst with ADDR_WIDTH=6, BURST_LEN=4, RD_LATENCY=2.
module tb_main_mem_burst;

    localparam int AW  = 6;
    localparam int DW  = 32;
    localparam int BL  = 4;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_ready = 1'b0;
    logic          flush = 1'b0;
    logic          req_ready;
    logic          wr_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          flush_busy;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    main_mem_burst #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .BURST_LEN (BL),
        .RD_LATENCY(LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .flush     (flush),
        .flush_busy(flush_busy)
    );

    // Entered and left on a falling edge; returns just after the accepting edge.
    task automatic issue_req(input logic we, input logic [AW-1:0] a, output bit ok);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (req_ready === 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic write_line(input logic [AW-1:0] a, input logic [DW-1:0] seed, output bit ok);
        issue_req(1'b1, a, ok);
        for (int i = 0; i < BL; i++) begin
            wr_valid = 1'b1;
            wr_data  = seed + DW'(i);
            @(negedge clk);
            if (i == 1) begin
                wr_valid = 1'b0;
                wr_data  = 32'hDEAD_BEEF;
                @(negedge clk);
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic read_line(input logic [AW-1:0] a, output logic [DW-1:0] q [BL],
                             output int lat, output bit ok);
        bit acc;
        int k;
        k   = 0;
        lat = -1;
        for (int i = 0; i < BL; i++) q[i] = '0;
        issue_req(1'b0, a, acc);
        rd_ready = 1'b1;
        for (int cyc = 0; cyc < 50 && k < BL; cyc++) begin
            if (rd_valid === 1'b1) begin
                if (k == 0) lat = cyc;
                q[k] = rd_data;
                k++;
            end
            @(negedge clk);
        end
        rd_ready = 1'b0;
        ok = acc && (k == BL);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        vectors++;
        if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b expected 0", wr_ready); end
        vectors++;
        if (flush_busy !== 1'b0) begin errors++; $display("FAIL reset_flush_busy: got %b expected 0", flush_busy); end
        vectors++;
        if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_write_read();
        bit ok;
        int lat;
        logic [DW-1:0] q [BL];
        write_line(6'h08, 32'hA0, ok);
        vectors++;
        if (!ok) begin errors++; $display("FAIL wr_accept: got 0 expected 1"); end
        vectors++;
        if (wr_ready !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_done: got wr_ready=%b req_ready=%b expected 0/1", wr_ready, req_ready);
        end
        read_line(6'h08, q, lat, ok);
        vectors++;
        if (!ok) begin errors++; $display("FAIL rd_complete: got 0 expected 1"); end
        vectors++;
        if (lat != LAT) begin errors++; $display("FAIL rd_latency: got %0d expected %0d", lat, LAT); end
        for (int i = 0; i < BL; i++) begin
            vectors++;
            if (q[i] !== 32'hA0 + DW'(i)) begin
                errors++;
                $display("FAIL rd_beat%0d: got %h expected %h", i, q[i], 32'hA0 + DW'(i));
            end
        end
    endtask

    task automatic test_unaligned();
        bit ok;
        int lat;
        logic [DW-1:0] q [BL];
        logic [DW-1:0] exp;
        read_line(6'h0A, q, lat, ok);
        vectors++;
        if (!ok) begin errors++; $display("FAIL unal_complete: got 0 expected 1"); end
        for (int i = 0; i < BL; i++) begin
`ifdef CRITICAL_WORD_FIRST_EN
            exp = 32'hA0 + DW'((i + 2) % BL);
`else
            exp = 32'hA0 + DW'(i);
`endif
            vectors++;
            if (q[i] !== exp) begin
                errors++;
                $display("FAIL unal_beat%0d: got %h expected %h", i, q[i], exp);
            end
        end
        // Writes are always line-aligned regardless of the requested offset.
        write_line(6'h0E, 32'hC0, ok);
        read_line(6'h0C, q, lat, ok);
        for (int i = 0; i < BL; i++) begin
            vectors++;
            if (q[i] !== 32'hC0 + DW'(i)) begin
                errors++;
                $display("FAIL unal_wr_beat%0d: got %h expected %h", i, q[i], 32'hC0 + DW'(i));
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        bit prev_stall;
        int got;
        logic [DW-1:0] prev;
        issue_req(1'b0, 6'h08, ok);
        got = 0;
        prev_stall = 1'b0;
        prev = '0;
        for (int cyc = 0; cyc < 60 && got < BL; cyc++) begin
            rd_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (prev_stall) begin
                vectors++;
                if (rd_valid !== 1'b1 || rd_data !== prev) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b data=%h expected 1/%h", rd_valid, rd_data, prev);
                end
            end
            if (rd_valid === 1'b1) begin
                if (rd_ready) begin
                    vectors++;
                    if (rd_data !== 32'hA0 + DW'(got)) begin
                        errors++;
                        $display("FAIL stall_beat%0d: got %h expected %h", got, rd_data, 32'hA0 + DW'(got));
                    end
                    got++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev = rd_data;
                end
            end
            @(negedge clk);
        end
        rd_ready = 1'b0;
        vectors++;
        if (got != BL) begin errors++; $display("FAIL stall_count: got %0d expected %0d", got, BL); end
        vectors++;
        if (rd_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_end: got rd_valid=%b req_ready=%b expected 0/1", rd_valid, req_ready);
        end
    endtask

    task automatic test_flush_idle();
        bit ok;
        bit overlap;
        int lat;
        int n;
        logic [DW-1:0] q [BL];
        flush     = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 6'h10;
        @(negedge clk);
        flush = 1'b0;
        vectors++;
        if (flush_busy !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_start: got busy=%b req_ready=%b expected 1/0", flush_busy, req_ready);
        end
        n = 1;
        overlap = 1'b0;
        for (int k = 0; k < 200; k++) begin
            flush = (k == 10);
            @(negedge clk);
            if (flush_busy !== 1'b1) break;
            n++;
            if (req_ready !== 1'b0) overlap = 1'b1;
        end
        flush = 1'b0;
        req_valid = 1'b0;
        vectors++;
        if (n != 64) begin errors++; $display("FAIL flush_len: got %0d expected 64", n); end
        vectors++;
        if (overlap) begin errors++; $display("FAIL flush_req_ready: got 1 expected 0"); end
        vectors++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_end: got %b expected 1", req_ready); end
        read_line(6'h08, q, lat, ok);
        for (int i = 0; i < BL; i++) begin
            vectors++;
            if (q[i] !== '0) begin errors++; $display("FAIL flush_rd08_%0d: got %h expected 0", i, q[i]); end
        end
        read_line(6'h3C, q, lat, ok);
        vectors++;
        if (!ok || q[3] !== '0) begin errors++; $display("FAIL flush_rd3f: got %h expected 0", q[3]); end
    endtask

    task automatic test_flush_mid_write();
        bit ok;
        int lat;
        int n;
        logic [DW-1:0] q [BL];
        issue_req(1'b1, 6'h20, ok);
        for (int i = 0; i < BL; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'hD0 + DW'(i);
            flush    = (i == 1);
            vectors++;
            if (wr_ready !== 1'b1 || flush_busy !== 1'b0) begin
                errors++;
                $display("FAIL midwr_beat%0d: got wr_ready=%b busy=%b expected 1/0", i, wr_ready, flush_busy);
            end
            @(negedge clk);
        end
        wr_valid  = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 6'h00;
        @(negedge clk);
        req_valid = 1'b0;
        vectors++;
        if (flush_busy !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL midwr_clear: got busy=%b req_ready=%b expected 1/0", flush_busy, req_ready);
        end
        n = 1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (flush_busy !== 1'b1) break;
            n++;
        end
        vectors++;
        if (n != 64) begin errors++; $display("FAIL midwr_len: got %0d expected 64", n); end
        read_line(6'h20, q, lat, ok);
        for (int i = 0; i < BL; i++) begin
            vectors++;
            if (q[i] !== '0) begin errors++; $display("FAIL midwr_rd%0d: got %h expected 0", i, q[i]); end
        end
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        int lat;
        logic [DW-1:0] q [BL];
        logic [DW-1:0] exp [BL];
        write_line(6'h08, 32'hE0, ok);
        issue_req(1'b1, 6'h08, ok);
        wr_valid = 1'b1;
        wr_data  = 32'hF0;
        @(negedge clk);
        wr_data  = 32'hF1;
        @(negedge clk);
        wr_data  = 32'hF2;
        rst_n    = 1'b0;
        #1;
        vectors++;
        if (wr_ready !== 1'b0 || rd_valid !== 1'b0 || flush_busy !== 1'b0 || rd_data !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got wr=%b rd=%b busy=%b data=%h expected 0/0/0/0",
                     wr_ready, rd_valid, flush_busy, rd_data);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_req_ready: got %b expected 1", req_ready); end
        exp[0] = 32'hF0;
        exp[1] = 32'hF1;
        exp[2] = 32'hE2;
        exp[3] = 32'hE3;
        read_line(6'h08, q, lat, ok);
        for (int i = 0; i < BL; i++) begin
            vectors++;
            if (q[i] !== exp[i]) begin
                errors++;
                $display("FAIL rstmid_rd%0d: got %h expected %h", i, q[i], exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_unaligned();
        test_stall();
        test_flush_idle();
        test_flush_mid_write();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
